// File: rtl/alu_share_ctrl.sv
// Two-requester arbiter and two-stage issue/retire pipeline for the shared 16-bit ALU.
// Also owns the architectural carry/zero flags, written only by flag-writing requester-0 ops.
module alu_share_ctrl #(
  parameter int WIDTH = 16,
  parameter int FW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  input  logic [FW-1:0]    r0_f,
  input  logic             r0_wflags,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  input  logic [FW-1:0]    r1_f,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [FW-1:0]    alu_f,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_c,
  input  logic             alu_z,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_y,
  output logic             rsp_c,
  output logic             rsp_z,
  output logic             flag_c,
  output logic             flag_z,
  output logic             busy
);

  logic last_grant;  // 1: requester 1 was granted last
  logic s1_valid;
  logic s1_id;
  logic s1_wflags;
  logic grant0;
  logic grant1;
  logic accept0;
  logic accept1;
  logic accept;
  logic retire;

  always_comb begin
    grant0  = r0_valid & (~r1_valid | last_grant);
    grant1  = r1_valid & (~r0_valid | ~last_grant);
    accept0 = r0_valid & r0_ready;
    accept1 = r1_valid & r1_ready;
    accept  = accept0 | accept1;
    retire  = s1_valid & ~flush;
  end

  assign r0_ready = grant0 & ~flush;
  assign r1_ready = grant1 & ~flush;
  assign busy     = s1_valid | rsp_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_f      <= '0;
      s1_valid   <= 1'b0;
      s1_id      <= 1'b0;
      s1_wflags  <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        alu_a      <= accept0 ? r0_a : r1_a;
        alu_b      <= accept0 ? r0_b : r1_b;
        alu_f      <= accept0 ? r0_f : r1_f;
        s1_id      <= accept1;
        s1_wflags  <= accept0 & r0_wflags;
        last_grant <= accept1;
      end
    end
  end

  // A flushed op neither produces a response nor writes flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_y     <= '0;
      rsp_c     <= 1'b0;
      rsp_z     <= 1'b0;
      flag_c    <= 1'b0;
      flag_z    <= 1'b0;
    end else begin
      rsp_valid <= retire;
      if (retire) begin
        rsp_id <= s1_id;
        rsp_y  <= alu_y;
        rsp_c  <= alu_c;
        rsp_z  <= alu_z;
        if (!s1_id && s1_wflags) begin
          flag_c <= alu_c;
          flag_z <= alu_z;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a small behavioural ALU closing the loop.
module tb_alu_share_ctrl;
  localparam int WIDTH = 16;
  localparam int FW    = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             r0_valid, r0_ready, r0_wflags;
  logic [WIDTH-1:0] r0_a, r0_b;
  logic [FW-1:0]    r0_f;
  logic             r1_valid, r1_ready;
  logic [WIDTH-1:0] r1_a, r1_b;
  logic [FW-1:0]    r1_f;
  logic [WIDTH-1:0] alu_a, alu_b, alu_y;
  logic [FW-1:0]    alu_f;
  logic             alu_c, alu_z;
  logic             rsp_valid, rsp_id, rsp_c, rsp_z;
  logic [WIDTH-1:0] rsp_y;
  logic             flag_c, flag_z, busy;

  int n_checks = 0;
  int n_pass   = 0;

  alu_share_ctrl #(.WIDTH(WIDTH), .FW(FW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b),
    .r0_f(r0_f), .r0_wflags(r0_wflags),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_f(r1_f),
    .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
    .alu_y(alu_y), .alu_c(alu_c), .alu_z(alu_z),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_c(rsp_c), .rsp_z(rsp_z),
    .flag_c(flag_c), .flag_z(flag_z), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: ADD, AND, OR, XOR.
  logic [WIDTH:0] sum;
  always_comb begin
    sum   = {1'b0, alu_a} + {1'b0, alu_b};
    alu_c = 1'b0;
    case (alu_f)
      3'd0:    {alu_c, alu_y} = sum;
      3'd1:    alu_y = alu_a & alu_b;
      3'd2:    alu_y = alu_a | alu_b;
      default: alu_y = alu_a ^ alu_b;
    endcase
    alu_z = (alu_y == '0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0;
    r0_valid = 1'b0; r0_a = '0; r0_b = '0; r0_f = '0; r0_wflags = 1'b0;
    r1_valid = 1'b0; r1_a = '0; r1_b = '0; r1_f = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic drive_r0(input logic [15:0] a, input logic [15:0] b, input logic wf);
    r0_valid = 1'b1; r0_a = a; r0_b = b; r0_f = 3'd0; r0_wflags = wf;
  endtask

  logic [15:0] exp_y [4];
  int n0, n1;

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #12;
    check("rst_alu_a", 32'(alu_a), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_y", 32'(rsp_y), 0);
    check("rst_flags", 32'({flag_c, flag_z}), 0);
    check("rst_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // single op: 0x7FFF + 1
    drive_r0(16'h7FFF, 16'h0001, 1'b1);
    #1;
    check("single_r0_ready", 32'(r0_ready), 1);
    step();
    r0_valid = 1'b0;
    check("single_alu_a", 32'(alu_a), 32'h7FFF);
    check("single_busy", 32'(busy), 1);
    check("single_rsp_early", 32'(rsp_valid), 0);
    step();
    check("single_rsp_valid", 32'(rsp_valid), 1);
    check("single_rsp_id", 32'(rsp_id), 0);
    check("single_rsp_y", 32'(rsp_y), 32'h8000);
    check("single_flags", 32'({flag_c, flag_z}), 0);
    step();
    check("single_rsp_pulse", 32'(rsp_valid), 0);
    check("single_busy_done", 32'(busy), 0);

    // carry and zero, then r1 op leaves flags alone
    drive_r0(16'hFFFF, 16'h0001, 1'b1);
    step();
    r0_valid = 1'b0;
    step();
    check("cz_rsp_y", 32'(rsp_y), 0);
    check("cz_rsp_cz", 32'({rsp_c, rsp_z}), 3);
    check("cz_flags", 32'({flag_c, flag_z}), 3);
    r1_valid = 1'b1; r1_a = 16'h0002; r1_b = 16'h0003; r1_f = 3'd0;
    #1;
    check("r1_ready", 32'(r1_ready), 1);
    step();
    r1_valid = 1'b0;
    step();
    check("r1_rsp_valid", 32'(rsp_valid), 1);
    check("r1_rsp_id", 32'(rsp_id), 1);
    check("r1_rsp_y", 32'(rsp_y), 5);
    check("r1_flags_kept", 32'({flag_c, flag_z}), 3);
    step();

    // contention from reset: grants 0,1,0,1, responses back to back
    do_reset();
    exp_y[0] = 16'h0011; exp_y[1] = 16'h0101; exp_y[2] = 16'h0012; exp_y[3] = 16'h0102;
    n0 = 0; n1 = 0;
    for (int i = 0; i < 4; i++) begin
      r0_valid = 1'b1; r0_b = 16'h0001; r0_f = 3'd0; r0_wflags = 1'b1;
      r0_a = 16'(16'h0010 + n0);
      r1_valid = 1'b1; r1_b = 16'h0001; r1_f = 3'd0;
      r1_a = 16'(16'h0100 + n1);
      #1;
      check($sformatf("rr_r0_ready_%0d", i), 32'(r0_ready), (i % 2 == 0) ? 1 : 0);
      check($sformatf("rr_r1_ready_%0d", i), 32'(r1_ready), (i % 2 == 0) ? 0 : 1);
      step();
      if (i % 2 == 0) n0++;
      else n1++;
      if (i > 0) begin
        check($sformatf("rr_rsp_valid_%0d", i - 1), 32'(rsp_valid), 1);
        check($sformatf("rr_rsp_id_%0d", i - 1), 32'(rsp_id), 32'((i - 1) % 2));
        check($sformatf("rr_rsp_y_%0d", i - 1), 32'(rsp_y), 32'(exp_y[i - 1]));
      end
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
    step();
    check("rr_rsp_valid_3", 32'(rsp_valid), 1);
    check("rr_rsp_id_3", 32'(rsp_id), 1);
    check("rr_rsp_y_3", 32'(rsp_y), 32'(exp_y[3]));
    step();
    check("rr_rsp_done", 32'(rsp_valid), 0);

    // flush kills the op in S1 and blocks both readies
    drive_r0(16'hFFFF, 16'h0001, 1'b1);
    step();
    flush = 1'b1;
    r0_valid = 1'b1; r0_a = 16'h0001; r0_b = 16'h0001; r0_wflags = 1'b1;
    r1_valid = 1'b1;
    #1;
    check("flush_r0_ready", 32'(r0_ready), 0);
    check("flush_r1_ready", 32'(r1_ready), 0);
    step();
    idle_inputs();
    check("flush_rsp_valid", 32'(rsp_valid), 0);
    check("flush_flags", 32'({flag_c, flag_z}), 0);
    check("flush_busy", 32'(busy), 0);
    step();
    check("flush_no_late_rsp", 32'(rsp_valid), 0);

    // reset mid-operation
    drive_r0(16'hFFFF, 16'h0001, 1'b1);
    step();
    drive_r0(16'h1234, 16'h1111, 1'b1);
    step();
    r0_valid = 1'b0;
    check("pre_rst_flags", 32'({flag_c, flag_z}), 3);
    check("pre_rst_rsp_valid", 32'(rsp_valid), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", 32'(rsp_valid), 0);
    check("midrst_rsp_y", 32'(rsp_y), 0);
    check("midrst_flags", 32'({flag_c, flag_z}), 0);
    check("midrst_alu_a", 32'(alu_a), 0);
    check("midrst_alu_b", 32'(alu_b), 0);
    check("midrst_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("postrst_rsp_0", 32'(rsp_valid), 0);
    step();
    check("postrst_rsp_1", 32'(rsp_valid), 0);

    // first tie after reset goes to r0; r1 then withdraws
    drive_r0(16'h0003, 16'h0004, 1'b0);
    r1_valid = 1'b1; r1_a = 16'h0100; r1_b = 16'h0100; r1_f = 3'd0;
    #1;
    check("tie_r0_ready", 32'(r0_ready), 1);
    check("tie_r1_ready", 32'(r1_ready), 0);
    step();
    r0_valid = 1'b0; r1_valid = 1'b0;
    step();
    check("wd_rsp_valid", 32'(rsp_valid), 1);
    check("wd_rsp_id", 32'(rsp_id), 0);
    check("wd_rsp_y", 32'(rsp_y), 7);
    step();
    check("wd_no_r1_rsp", 32'(rsp_valid), 0);
    drive_r0(16'h0001, 16'h0001, 1'b0);
    r1_valid = 1'b1;
    #1;
    check("wd_next_tie_r1", 32'(r1_ready), 1);
    check("wd_next_tie_r0", 32'(r0_ready), 0);
    step();
    idle_inputs();
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Sequencer and arbiter for the shared 16-bit ALU (adder, carry generator, logic ops). It accepts operations from two requesters, the execute stage (requester 0) and the load/store-multiple address incrementer (requester 1). It issues one operation per cycle through a two-stage registered pipeline and returns tagged results. It also owns the architectural carry and zero flag registers and updates them only on flag-writing requester-0 operations.

## Interface
- WIDTH, 16, data/operand width
- FW, 3, ALU function-select width (F=000 is ADD)

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous kill of all in-flight operations
- r0_valid  in  1  requester 0 has an operation
- r0_ready  out  1  requester 0 operation accepted this cycle
- r0_a, r0_b  in  WIDTH  requester 0 operands
- r0_f  in  FW  requester 0 function
- r0_wflags  in  1  requester 0 operation writes C/Z flags
- r1_valid  in  1  requester 1 has an operation
- r1_ready  out  1  requester 1 operation accepted this cycle
- r1_a, r1_b  in  WIDTH  requester 1 operands
- r1_f  in  FW  requester 1 function
- alu_a, alu_b  out  WIDTH  registered ALU operands
- alu_f  out  FW  registered ALU function
- alu_y  in  WIDTH  ALU result (combinational from alu_a/b/f)
- alu_c, alu_z  in  1  ALU carry / zero
- rsp_valid  out  1  result valid, single-cycle pulse, no backpressure
- rsp_id  out  1  requester that owns the result
- rsp_y  out  WIDTH  result
- rsp_c, rsp_z  out  1  carry/zero of this result
- flag_c, flag_z  out  1  architectural flags
- busy  out  1  S1 or S2 valid

## Operation
- Arbitration:
  - Combinational round-robin over r0_valid/r1_valid. A lone request is always granted.
  - On a tie, the requester not granted last wins.
  - last_grant updates only on accept; reset value 1, so r0 wins the first tie.
- Accept is rX_valid & rX_ready. rX_ready is high only for the granted requester, and never while flush=1. At most one accept per cycle.
- A requester holds its valid and operands stable until ready. Dropping valid before ready is permitted (the request is withdrawn).
- S1 (issue):
  - On accept, register operands/function into alu_a/alu_b/alu_f, plus s1_valid=1, s1_id, and s1_wflags (r0_wflags for r0, forced 0 for r1).
  - With no accept, s1_valid=0 and alu_a/b/f hold their last values.
- S2 (retire):
  - When s1_valid, capture alu_y/alu_c/alu_z into rsp_y/rsp_c/rsp_z, set rsp_valid=1, rsp_id=s1_id.
  - Otherwise rsp_valid=0; data holds.
- Flags: flag_c/flag_z load alu_c/alu_z on the same edge as S2 capture iff s1_valid & s1_id==0 & s1_wflags. Requester-1 results never touch flags.
- flush:
  - Clears s1_valid and rsp_valid at the next edge and blocks accept that cycle.
  - Suppresses the flag write of the operation in S1.
  - Flags already written stay. last_grant is unchanged.
- Full throughput: a new accept is possible every cycle. There is no stall path because the response has no backpressure.

## Timing
- Latency: accept on edge N → alu_a/b/f valid in cycle N..N+1 → rsp_valid high for one cycle after edge N+1 (2 edges).
- Flags reflect an op from the same edge that raises its rsp_valid.
- Back-to-back accepts on edges N and N+1 produce rsp_valid on consecutive cycles, in accept order.
- Reset (async assert, any time, including mid-operation):
  - All outputs 0: alu_a/b/f, rsp_*, flag_c, flag_z, busy.
  - s1_valid=0, last_grant=1.
  - In-flight operations are lost. No rsp_valid pulse is produced for them after reset release.
- First accept is possible on the first rising edge after rst_n deasserts.
- flush and accept never coincide; flush has priority.

## Test plan
- Single op: r0 ADD a=0x7FFF b=0x0001 wflags=1 → two edges later rsp_valid=1, rsp_id=0, rsp_y=0x8000, flag_c=0, flag_z=0.
- Carry and zero: r0 ADD 0xFFFF+0x0001 wflags=1 → rsp_y=0x0000, rsp_c=1, flag_c=1, flag_z=1. Then r1 ADD 0x0002+0x0003 → rsp_y=0x0005, rsp_id=1, flags stay C=1, Z=1.
- Contention: both valid continuously for 4 cycles from reset → grant order 0,1,0,1. Four consecutive rsp_valid pulses with rsp_id 0,1,0,1, no idle gaps.
- Flush: r0 ADD 0xFFFF+0x0001 wflags=1 accepted, flush=1 the next cycle → no rsp_valid for that op, flags unchanged (0,0), r0_ready/r1_ready low during flush.
- Reset mid-operation: accept an op, assert rst_n=0 before retire → all outputs 0 immediately. After release no stray rsp_valid, and the first tie goes to r0.
- Withdrawn request: r1_valid pulses for one cycle while r0 wins the tie → no r1 accept, no response for r1, last_grant stays on 0.
